// File: rtl/button_event_if.sv
// rtl/button_event_if.sv - button event bus between debouncer side and game controller
// Purpose: bundles the per-button inputs (tick, btn_in) and the event outputs.
// Ports (slave view, i.e. the button_event block):
//   tick        in   1   one-cycle 1 ms strobe, clk domain
//   btn_in      in   1   debounced button level
//   press       out  1   one-cycle strobe on press
//   release_evt out  1   one-cycle strobe on release
//   long_press  out  1   one-cycle strobe once per press after LONG_MS ticks
//   repeat_evt  out  1   one-cycle strobe every REP_MS ticks after long_press
//   held        out  1   level, high from press until release
//   hold_ms     out  CW  saturating tick count since press
interface button_event_if #(
  parameter int unsigned CW = 12
);
  logic          tick;
  logic          btn_in;
  logic          press;
  logic          release_evt;
  logic          long_press;
  logic          repeat_evt;
  logic          held;
  logic [CW-1:0] hold_ms;

  modport master (
    output tick, btn_in,
    input  press, release_evt, long_press, repeat_evt, held, hold_ms
  );

  modport slave (
    input  tick, btn_in,
    output press, release_evt, long_press, repeat_evt, held, hold_ms
  );
endinterface

// File: rtl/button_event.sv
// rtl/button_event.sv - converts a debounced button level into press/release/long/repeat strobes
// Purpose: one instance per button; measures hold time by counting the external
// 1 ms tick and emits one-clock event strobes plus a saturating hold duration.
// Ports:
//   clk  in  1   system clock
//   rst  in  1   synchronous active-high reset
//   bus  slave modport of button_event_if (tick, btn_in in; events, held, hold_ms out)
module button_event #(
  parameter int unsigned CW         = 12,
  parameter int unsigned LONG_MS    = 800,
  parameter int unsigned REP_MS     = 150,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input logic           clk,
  input logic           rst,
  button_event_if.slave bus
);

  localparam logic [CW-1:0] LONG_V = CW'(LONG_MS);
  localparam logic [CW-1:0] REP_V  = CW'(REP_MS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_t;

  state_t        state;
  logic          s;
  logic          s_prev;
  logic          press_q;
  logic          release_q;
  logic          long_q;
  logic          repeat_q;
  logic          held_q;
  logic [CW-1:0] hold_q;
  logic [CW-1:0] rep_cnt;

  logic          rise;
  logic          fall;
  logic [CW-1:0] hold_inc;
  logic [CW-1:0] rep_inc;

  // The sampler keeps running through reset so a button held across reset
  // looks like a steady level afterwards and never produces a press.
  always_ff @(posedge clk) begin
    s      <= bus.btn_in ^ ACTIVE_LOW;
    s_prev <= s;
  end

  always_comb begin
    rise     = s & ~s_prev;
    fall     = ~s & s_prev;
    hold_inc = (hold_q == '1) ? hold_q : hold_q + CW'(1);
    rep_inc  = rep_cnt + CW'(1);
  end

  // Release is tested before tick so a coincident tick is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
      hold_q    <= '0;
      rep_cnt   <= '0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            press_q <= 1'b1;
            held_q  <= 1'b1;
            hold_q  <= '0;
            rep_cnt <= '0;
            state   <= PRESSED;
          end
        end
        PRESSED: begin
          if (fall) begin
            release_q <= 1'b1;
            held_q    <= 1'b0;
            state     <= IDLE;
          end else if (bus.tick) begin
            hold_q <= hold_inc;
            if (hold_inc == LONG_V) begin
              long_q  <= 1'b1;
              rep_cnt <= '0;
              state   <= LONG;
            end
          end
        end
        LONG: begin
          if (fall) begin
            release_q <= 1'b1;
            held_q    <= 1'b0;
            state     <= IDLE;
          end else if (bus.tick) begin
            hold_q <= hold_inc;
            // rep_cnt keeps counting past hold_ms saturation so repeats continue.
            if (rep_inc == REP_V) begin
              repeat_q <= 1'b1;
              rep_cnt  <= '0;
            end else begin
              rep_cnt <= rep_inc;
            end
          end
        end
        default: begin
          state  <= IDLE;
          held_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.press       = press_q;
  assign bus.release_evt = release_q;
  assign bus.long_press  = long_q;
  assign bus.repeat_evt  = repeat_q;
  assign bus.held        = held_q;
  assign bus.hold_ms     = hold_q;

endmodule

// File: tb/tb_button_event.sv
// tb/tb_button_event.sv - self-checking bench for button_event
module tb_button_event;

  localparam int CW      = 4;
  localparam int LONG_MS = 3;
  localparam int REP_MS  = 2;
  localparam int HMAX    = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  button_event_if #(.CW(CW)) bus0 ();
  button_event_if #(.CW(CW)) bus1 ();

  button_event #(.CW(CW), .LONG_MS(LONG_MS), .REP_MS(REP_MS), .ACTIVE_LOW(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  button_event #(.CW(CW), .LONG_MS(LONG_MS), .REP_MS(REP_MS), .ACTIVE_LOW(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  logic [8:0] got [2];
  assign got[0] = {bus0.press, bus0.release_evt, bus0.long_press, bus0.repeat_evt, bus0.held, bus0.hold_ms};
  assign got[1] = {bus1.press, bus1.release_evt, bus1.long_press, bus1.repeat_evt, bus1.held, bus1.hold_ms};

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int phase    = 0;

  // Reference model: an event is a function of "ticks counted since press".
  bit m_s [2], m_sp [2], m_on [2];
  int m_cnt [2];
  bit e_press [2], e_rel [2], e_long [2], e_rpt [2];

  int c_press [2], c_rel [2], c_long [2], c_rpt [2], c_held [2];

  typedef struct {
    bit         r, b, t;
    bit         p, rl, lp, rp, hd;
    logic [3:0] hm;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string name, input int actual, input int required);
    n_checks++;
    if (actual !== required) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d required %0d", name, cyc, actual, required);
    end
  endtask

  task automatic model_step(input int i, input bit r, input bit b, input bit t);
    bit rise, fall;
    rise = m_s[i] && !m_sp[i];
    fall = !m_s[i] && m_sp[i];
    e_press[i] = 0; e_rel[i] = 0; e_long[i] = 0; e_rpt[i] = 0;
    if (r) begin
      m_on[i]  = 0;
      m_cnt[i] = 0;
    end else if (!m_on[i]) begin
      if (rise) begin
        e_press[i] = 1;
        m_on[i]    = 1;
        m_cnt[i]   = 0;
      end
    end else if (fall) begin
      e_rel[i] = 1;
      m_on[i]  = 0;
    end else if (t) begin
      m_cnt[i]++;
      if (m_cnt[i] == LONG_MS) e_long[i] = 1;
      else if (m_cnt[i] > LONG_MS && (m_cnt[i] - LONG_MS) % REP_MS == 0) e_rpt[i] = 1;
    end
    m_sp[i] = m_s[i];
    m_s[i]  = b ^ (i == 1);
  endtask

  function automatic logic [8:0] exp_vec(input int i);
    int h;
    h = (m_cnt[i] > HMAX) ? HMAX : m_cnt[i];
    return {e_press[i], e_rel[i], e_long[i], e_rpt[i], m_on[i], 4'(h)};
  endfunction

  task automatic clear_counts();
    for (int i = 0; i < 2; i++) begin
      c_press[i] = 0; c_rel[i] = 0; c_long[i] = 0; c_rpt[i] = 0; c_held[i] = 0;
    end
  endtask

  task automatic step(input bit r, input bit b0, input bit b1, input bit t);
    rst         = r;
    bus0.btn_in = b0;
    bus1.btn_in = b1;
    bus0.tick   = t;
    bus1.tick   = t;
    @(posedge clk);
    #1;
    model_step(0, r, b0, t);
    model_step(1, r, b1, t);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("model_inst%0d", i), int'(got[i]), int'(exp_vec(i)));
      c_press[i] += int'(got[i][8]);
      c_rel[i]   += int'(got[i][7]);
      c_long[i]  += int'(got[i][6]);
      c_rpt[i]   += int'(got[i][5]);
      c_held[i]  += int'(got[i][4]);
    end
    cyc++;
  endtask

  // Fixed-period tick: one tick every 10 cycles, on phase 9.
  task automatic run(input int n, input bit b0, input bit b1);
    for (int k = 0; k < n; k++) begin
      step(1'b0, b0, b1, phase == 9);
      phase = (phase + 1) % 10;
    end
  endtask

  task automatic align();
    while (phase != 0) run(1, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    bus0.btn_in = 1'b0; bus1.btn_in = 1'b1;
    bus0.tick = 1'b0;   bus1.tick = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_s[i] = 0; m_sp[i] = 0; m_on[i] = 0; m_cnt[i] = 0;
    end
    clear_counts();

    // Reset, then a 5-cycle press with no tick.
    //            r  b  t   p rl lp rp hd hm
    tbl[0] = '{1, 0, 0,  0, 0, 0, 0, 0, 4'd0};
    tbl[1] = '{1, 0, 0,  0, 0, 0, 0, 0, 4'd0};
    tbl[2] = '{0, 1, 0,  0, 0, 0, 0, 0, 4'd0};
    tbl[3] = '{0, 1, 0,  1, 0, 0, 0, 1, 4'd0};
    tbl[4] = '{0, 1, 0,  0, 0, 0, 0, 1, 4'd0};
    tbl[5] = '{0, 1, 0,  0, 0, 0, 0, 1, 4'd0};
    tbl[6] = '{0, 1, 0,  0, 0, 0, 0, 1, 4'd0};
    tbl[7] = '{0, 0, 0,  0, 0, 0, 0, 1, 4'd0};
    tbl[8] = '{0, 0, 0,  0, 1, 0, 0, 0, 4'd0};
    tbl[9] = '{0, 0, 0,  0, 0, 0, 0, 0, 4'd0};
    for (int v = 0; v < 10; v++) begin
      step(tbl[v].r, tbl[v].b, 1'b1, tbl[v].t);
      chk($sformatf("vec%0d", v), int'(got[0]),
          int'({tbl[v].p, tbl[v].rl, tbl[v].lp, tbl[v].rp, tbl[v].hd, tbl[v].hm}));
    end
    phase = 0;

    // Hold for 9 ticks.
    align(); clear_counts();
    run(90, 1'b1, 1'b1);
    chk("hold9_press", c_press[0], 1);
    chk("hold9_long", c_long[0], 1);
    chk("hold9_repeat", c_rpt[0], 3);
    chk("hold9_hold_ms", int'(bus0.hold_ms), 9);
    run(3, 1'b0, 1'b1);
    chk("hold9_release", c_rel[0], 1);
    run(5, 1'b0, 1'b1);
    chk("hold9_hold_kept", int'(bus0.hold_ms), 9);
    chk("hold9_held_low", int'(bus0.held), 0);

    // Hold for 20 ticks: saturation, repeats continue.
    align(); clear_counts();
    run(200, 1'b1, 1'b1);
    chk("hold20_hold_ms", int'(bus0.hold_ms), HMAX);
    chk("hold20_long", c_long[0], 1);
    chk("hold20_repeat", c_rpt[0], 8);
    run(3, 1'b0, 1'b1);
    chk("hold20_release", c_rel[0], 1);

    // Release coincides with tick 3.
    align(); clear_counts();
    run(28, 1'b1, 1'b1);
    run(5, 1'b0, 1'b1);
    chk("rel_tick_release", c_rel[0], 1);
    chk("rel_tick_long", c_long[0], 0);
    chk("rel_tick_hold_ms", int'(bus0.hold_ms), 2);

    // Button held through reset.
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b1, 1'b0);
    clear_counts();
    run(5, 1'b1, 1'b1);
    run(6, 1'b0, 1'b1);
    chk("rst_held_events", c_press[0] + c_rel[0] + c_long[0] + c_rpt[0], 0);
    chk("rst_held_held", c_held[0], 0);
    run(4, 1'b1, 1'b1);
    chk("rst_held_press", c_press[0], 1);
    run(4, 1'b0, 1'b1);

    // Active-low instance: low for 4 cycles.
    clear_counts();
    run(4, 1'b0, 1'b0);
    run(5, 1'b0, 1'b1);
    chk("al_press", c_press[1], 1);
    chk("al_release", c_rel[1], 1);
    chk("al_held_cycles", c_held[1], 4);

    // Randomized traffic against the model, with occasional reset.
    begin
      bit rb0, rb1;
      rb0 = 0; rb1 = 1;
      for (int k = 0; k < 4000; k++) begin
        if ($urandom_range(7) == 0) rb0 = ~rb0;
        if ($urandom_range(9) == 0) rb1 = ~rb1;
        step($urandom_range(299) == 0, rb0, rb1, $urandom_range(2) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
